// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
//
// Shared definitions for the instruction-fetch stage: bus widths, stall-bit
// polarity and indices, the reset PC, and the hold-state encoding used by
// the decode-side instruction holder.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    // Bus widths shared with the rest of the pipeline.
    localparam int STALL_BUS_W = 6;
    localparam int BR_WD       = 33;   // {br_e, br_addr[31:0]}
    localparam int IF_TO_ID_WD = 33;   // {ce, pc[31:0]}

    // Stall-vector bit polarity.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall-vector bit positions.
    localparam int STALL_PC   = 0;     // PC register
    localparam int STALL_IFID = 1;     // IF/ID register
    localparam int STALL_IDEX = 2;     // ID/EX register

    // Address of the first instruction fetched after reset.
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    // Tracks what decode's IF/ID register currently holds, relative to the
    // SRAM read data.
    typedef enum logic [1:0] {
        HST_PASS   = 2'd0,   // decode's word is on inst_sram_rdata
        HST_HELD   = 2'd1,   // decode's word was captured into inst_buf
        HST_BUBBLE = 2'd2    // decode holds a bubble
    } hst_e;

    // What decode's IF/ID register does at the coming clock edge.
    typedef enum logic [1:0] {
        ACT_ADV  = 2'd0,
        ACT_BUB  = 2'd1,
        ACT_HOLD = 2'd2
    } id_act_e;

    // stall_id = {stall[STALL_IDEX], stall[STALL_IFID]}
    function automatic id_act_e id_action(input logic [1:0] stall_id);
        id_act_e act;
        if (stall_id[0] == NO_STOP) begin
            act = ACT_ADV;
        end else if (stall_id[1] == NO_STOP) begin
            act = ACT_BUB;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/id_inst_hold.sv
// ---------------------------------------------------------------------------
// id_inst_hold
//
// Shadows decode's IF/ID register so decode always sees the instruction word
// belonging to the PC it holds. While IF is frozen the SRAM keeps re-reading
// the IF-stage PC, so during a decode hold the raw read data belongs to the
// wrong instruction; the word is captured once on entry to the hold and
// replayed from inst_buf for the whole hold.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_id[1:0]     {stall[2], stall[1]} (ID/EX, IF/ID stall bits)
//   ce_reg            IF-stage valid bit being handed to decode
//   inst_sram_rdata   SRAM read data (word for the PC presented last cycle)
//   id_inst           instruction word for decode's current PC
//   hst               debug view of the hold state (hst_e encoding)
// ---------------------------------------------------------------------------
module id_inst_hold
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall_id,
    input  logic        ce_reg,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] id_inst,
    output logic [1:0]  hst
);

    hst_e        state_q;
    hst_e        state_d;
    logic [31:0] inst_buf;
    logic        buf_load;
    id_act_e     act;

    assign act = id_action(stall_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HST_BUBBLE;
            inst_buf <= 32'b0;
        end else begin
            state_q <= state_d;
            if (buf_load) begin
                inst_buf <= inst_sram_rdata;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_load = 1'b0;
        id_inst  = 32'b0;

        case (act)
            ACT_ADV: state_d = ce_reg ? HST_PASS : HST_BUBBLE;
            ACT_BUB: state_d = HST_BUBBLE;
            ACT_HOLD: begin
                // Capture only on the PASS->HELD edge; later hold cycles
                // would see rdata for the frozen IF PC.
                if (state_q == HST_PASS) begin
                    state_d  = HST_HELD;
                    buf_load = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase

        case (state_q)
            HST_PASS:   id_inst = inst_sram_rdata;
            HST_HELD:   id_inst = inst_buf;
            HST_BUBBLE: id_inst = 32'b0;
            default:    id_inst = 32'b0;
        endcase
    end

    assign hst = state_q;

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives
// the 1-cycle instruction SRAM, remembers a branch redirect that arrives
// while the PC is frozen, and supplies decode with a stable instruction word.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        pipeline stall vector (bit0 PC, bit1 IF/ID, bit2 ID/EX)
//   br_bus[32:0]      {br_e, br_addr} from decode
//   if_to_id_bus      {ce, pc} to decode
//   inst_sram_*       instruction SRAM port (read-only use)
//   id_inst           instruction word for the PC held in decode's IF/ID reg
//   dbg_hst           debug: hold state of the decode-side holder
//   dbg_pend_valid    debug: a frozen-PC redirect is pending
//
// Handshake: there is no valid/ready pair here. ce in if_to_id_bus marks a
// real fetch; the pipeline stall vector is the only back-pressure, and a
// stage only moves when its stall bit is NO_STOP at the clock edge.
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_BUS_W-1:0] stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [31:0]            id_inst,
    output logic [1:0]             dbg_hst,
    output logic                   dbg_pend_valid
);

    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic [31:0] next_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] hold_inst;
    logic        unused_stall;

    assign {br_e, br_addr} = br_bus;

    // Upper stall bits belong to later stages.
    assign unused_stall = ^stall[STALL_BUS_W-1:STALL_IDEX+1];

    // A live branch wins over a redirect remembered from a frozen cycle.
    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_valid) begin
            next_pc = pend_addr;
        end
    end

    // pc_reg resets to RESET_PC-4 so the first free-running increment lands
    // exactly on RESET_PC with ce_reg rising at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= RESET_PC - 32'd4;
            ce_reg     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= 32'b0;
        end else if (stall[STALL_PC] == NO_STOP) begin
            pc_reg     <= next_pc;
            ce_reg     <= 1'b1;
            pend_valid <= 1'b0;
        end else if (br_e) begin
            pend_valid <= 1'b1;
            pend_addr  <= br_addr;
        end
    end

    id_inst_hold u_id_inst_hold (
        .clk             (clk),
        .rst             (rst),
        .stall_id        (stall[STALL_IDEX:STALL_IFID]),
        .ce_reg          (ce_reg),
        .inst_sram_rdata (inst_sram_rdata),
        .id_inst         (hold_inst),
        .hst             (dbg_hst)
    );

    // Outputs read as idle for every cycle rst is high, including the first
    // one before the registers have taken their reset values.
    assign if_to_id_bus    = rst ? {IF_TO_ID_WD{1'b0}} : {ce_reg, pc_reg};
    assign inst_sram_en    = ce_reg & ~rst;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'b0;
    assign id_inst         = rst ? 32'b0 : hold_inst;
    assign dbg_pend_valid  = pend_valid;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer side of the IF→ID bus and the consumer side of the branch bus that the decode stage resolves.
- Owns the PC register and drives the synchronous (1-cycle) instruction SRAM port.
- Keeps a branch redirect that arrives while the PC is frozen, so the redirect is not lost.
- Supplies decode with an instruction word, id_inst, that stays correct across decode holds and bubbles. Decode uses id_inst in place of raw inst_sram_rdata.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first instruction fetched after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  `StallBus (6)  pipeline stall vector. stall[0] = PC, stall[1] = IF/ID register, stall[2] = ID/EX register. Each bit is `Stop=1 or `NoStop=0.
- br_bus  in  `BR_WD (33)  {br_e, br_addr[31:0]} from decode.
- if_to_id_bus  out  `IF_TO_ID_WD (33)  {ce, pc[31:0]}.
- inst_sram_en  out  1  read enable.
- inst_sram_wen  out  4  always 4'b0000.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  always 0.
- inst_sram_rdata  in  32  read data, valid the cycle after the address is presented.
- id_inst  out  32  instruction belonging to the PC currently held in decode's IF/ID register.

Behaviour:
- Registers:
  - pc_reg (32), ce_reg (1).
  - pend_valid (1), pend_addr (32).
  - hold state hst ∈ {PASS, HELD, BUBBLE}.
  - inst_buf (32).
- Reset values:
  - pc_reg = RESET_PC−4 = 32'hBFBF_FFFC, ce_reg = 0.
  - pend_valid = 0, pend_addr = 0.
  - hst = BUBBLE, inst_buf = 0.
  - Outputs during reset: if_to_id_bus = 0, inst_sram_en = 0, id_inst = 0.
- Output mapping: if_to_id_bus = {ce_reg, pc_reg}; inst_sram_addr = pc_reg; inst_sram_en = ce_reg.
- Next PC, computed combinationally:
  - next_pc = br_e ? br_addr : pend_valid ? pend_addr : pc_reg+4.
  - +4 wraps modulo 2^32.
  - br_e takes priority over a pending redirect.
- PC update at the clock edge:
  - When stall[0]==NoStop: pc_reg <= next_pc, ce_reg <= 1, pend_valid <= 0.
  - When stall[0]==Stop: pc_reg and ce_reg hold. If br_e==1 in that cycle, pend_valid <= 1 and pend_addr <= br_addr; a later br_e during the same freeze overwrites pend_addr.
- Delay slot: when a branch is in decode, IF already holds the delay-slot PC. That PC is delivered normally, and the redirect applies to the fetch after it.
- Decode register action each edge (mirrors decode's register):
  - ADV: stall[1]==NoStop.
  - BUB: stall[1]==Stop and stall[2]==NoStop.
  - HOLD: stall[1]==Stop and stall[2]==Stop.
- Hold-state transitions:
  - ADV with ce_reg=1 → PASS.
  - ADV with ce_reg=0 → BUBBLE.
  - BUB → BUBBLE.
  - HOLD from PASS → HELD, and inst_buf <= inst_sram_rdata at that edge (captured exactly once).
  - HOLD from HELD or BUBBLE → unchanged; inst_buf unchanged.
- id_inst, combinational: PASS → inst_sram_rdata; HELD → inst_buf; BUBBLE → 32'b0.
- Why HELD is needed: while IF is frozen the SRAM re-reads pc_reg, which is the IF-stage instruction, not the decode one. HELD must therefore mask rdata for the entire hold.
- Simultaneous events:
  - br_e with stall[0]==NoStop: branch taken directly, nothing pended.
  - Pend capture and hold-state capture are independent and may happen on the same edge.
- rst has priority over all stall and br inputs on any cycle, including mid-hold and with a redirect pending. Reset discards the pending redirect and the buffer.

Decomposition:
- lib/defines.vh already supplies StallBus, Stop/NoStop, IF_TO_ID_WD, BR_WD.
- Add to it: `RESET_PC_DEF 32'hBFC0_0000 and the 2-bit hold-state encodings `HST_PASS=0, `HST_HELD=1, `HST_BUBBLE=2.
- One sub-module: id_inst_hold, containing the PASS/HELD/BUBBLE FSM, inst_buf and the id_inst mux. Its inputs are stall[2:1], ce_reg and inst_sram_rdata.

Test Plan:
1. Reset release, stall=0: cycle 1 shows if_to_id_bus = {1, BFC00000}, inst_sram_en = 1. Next cycle shows pc = BFC00004, and id_inst equals the SRAM word at BFC00000.
2. Branch with br_bus = {1, BFC00100} for one cycle while pc_reg = BFC00008: next pc = BFC00100. The delay-slot PC BFC00008 still reaches decode with its correct instruction.
3. Decode hold, stall = 6'b000111 for 3 cycles while decode holds the word at BFC00004 = 24010005: id_inst = 24010005 on every cycle even though rdata shows the word at BFC00008. Release gives PASS, with pc advancing to BFC0000C.
4. Bubble, stall = 6'b000011 for 1 cycle: id_inst = 0 in the following cycle. After release, the held IF PC reaches decode with its correct word.
5. Pended redirect: br_e = 1, br_addr = BFC00200 while stall[0] = Stop, then br_e = 0 and stall cleared: next pc = BFC00200 and pend_valid = 0 afterwards.
6. Reset during HELD with a redirect pending: all outputs return to their reset values. The first fetch after reset is BFC00000, and the stale pend_addr is never used.
